// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges W-stage writes with buffered multi-cycle results.
// A 2-entry FIFO holds results; starvation forces a one-cycle pipeline stall to drain one.
module wb_arbiter #(
  parameter int D_WIDTH      = 32,
  parameter int A_WIDTH      = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_write_w_i,
  input  logic [A_WIDTH-1:0] rd_w_i,
  input  logic [D_WIDTH-1:0] result_w_i,
  input  logic               md_valid_i,
  output logic               md_ready_o,
  input  logic [A_WIDTH-1:0] md_rd_i,
  input  logic [D_WIDTH-1:0] md_data_i,
  output logic               we3_o,
  output logic [A_WIDTH-1:0] a3_o,
  output logic [D_WIDTH-1:0] wd3_o,
  output logic               stall_o,
  output logic               md_pending_o
);

  localparam int CW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT - 1);

  typedef enum logic {NORMAL, FORCE} state_e;

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] rd_mem_q   [2];
  logic [D_WIDTH-1:0] data_mem_q [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;
  logic [CW-1:0]      starve_q, starve_d;
  logic               pipe_req, fifo_nonempty, enq, pop;

  assign fifo_nonempty = (count_q != 2'd0);
  assign md_ready_o    = (count_q < 2'd2);
  assign md_pending_o  = fifo_nonempty;
  assign stall_o       = (state_q == FORCE);
  assign pipe_req      = reg_write_w_i && (rd_w_i != '0);
  assign enq           = md_valid_i && md_ready_o && (md_rd_i != '0);

  always_comb begin
    pop   = 1'b0;
    we3_o = 1'b0;
    a3_o  = '0;
    wd3_o = '0;
    // Writes are suppressed while reset is asserted so buffered results never reach the file.
    if (!rst) begin
      if (state_q == FORCE) begin
        if (fifo_nonempty) begin
          pop   = 1'b1;
          we3_o = 1'b1;
          a3_o  = rd_mem_q[rd_ptr_q];
          wd3_o = data_mem_q[rd_ptr_q];
        end
      end else if (pipe_req) begin
        we3_o = 1'b1;
        a3_o  = rd_w_i;
        wd3_o = result_w_i;
      end else if (fifo_nonempty) begin
        pop   = 1'b1;
        we3_o = 1'b1;
        a3_o  = rd_mem_q[rd_ptr_q];
        wd3_o = data_mem_q[rd_ptr_q];
      end
    end
  end

  always_comb begin
    count_d  = count_q + 2'(enq) - 2'(pop);
    wr_ptr_d = wr_ptr_q ^ enq;
    rd_ptr_d = rd_ptr_q ^ pop;
    state_d  = state_q;
    starve_d = '0;
    // A blocked non-empty FIFO counts up; hitting the limit schedules a single forced drain.
    if (state_q == FORCE) begin
      state_d = NORMAL;
    end else if (fifo_nonempty && !pop) begin
      if (starve_q == STARVE_MAX) begin
        state_d = FORCE;
      end else begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NORMAL;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      starve_q <= starve_d;
      if (enq) begin
        rd_mem_q[wr_ptr_q]   <= md_rd_i;
        data_mem_q[wr_ptr_q] <= md_data_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SL = 4;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          regWriteW;
  logic [AW-1:0] rdW;
  logic [DW-1:0] resultW;
  logic          mdValid;
  logic          mdReady;
  logic [AW-1:0] mdRd;
  logic [DW-1:0] mdData;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic          stall;
  logic          mdPending;

  entry_t fifoQ[$];
  bit     modelForce;
  int     blockedCycles;
  int     checks;
  int     errors;

  logic          obsWe, obsStall, obsReady, obsPending;
  logic [AW-1:0] obsA3;
  logic [DW-1:0] obsWd3;

  always #5 clk = ~clk;

  wb_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_write_w_i(regWriteW),
    .rd_w_i       (rdW),
    .result_w_i   (resultW),
    .md_valid_i   (mdValid),
    .md_ready_o   (mdReady),
    .md_rd_i      (mdRd),
    .md_data_i    (mdData),
    .we3_o        (we3),
    .a3_o         (a3),
    .wd3_o        (wd3),
    .stall_o      (stall),
    .md_pending_o (mdPending)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the model, then advance the model.
  task automatic applyStimulus(input logic r, input logic wen, input logic [AW-1:0] rd,
                               input logic [DW-1:0] res, input logic mv,
                               input logic [AW-1:0] mrd, input logic [DW-1:0] mdat);
    logic          expWe;
    logic [AW-1:0] expA3;
    logic [DW-1:0] expWd3;
    bit            doPop, doEnq, pipeReq, expReady;
    rst       = r;
    regWriteW = wen;
    rdW       = rd;
    resultW   = res;
    mdValid   = mv;
    mdRd      = mrd;
    mdData    = mdat;
    #2;
    obsWe      = we3;
    obsA3      = a3;
    obsWd3     = wd3;
    obsStall   = stall;
    obsReady   = mdReady;
    obsPending = mdPending;
    pipeReq  = wen && (rd != 0);
    expReady = (fifoQ.size() < 2);
    expWe    = 1'b0;
    expA3    = '0;
    expWd3   = '0;
    doPop    = 1'b0;
    if (modelForce && fifoQ.size() > 0) begin
      expWe = 1'b1; expA3 = fifoQ[0].rd; expWd3 = fifoQ[0].data; doPop = 1'b1;
    end else if (!modelForce && pipeReq) begin
      expWe = 1'b1; expA3 = rd; expWd3 = res;
    end else if (!modelForce && fifoQ.size() > 0) begin
      expWe = 1'b1; expA3 = fifoQ[0].rd; expWd3 = fifoQ[0].data; doPop = 1'b1;
    end
    doEnq = mv && expReady && (mrd != 0);
    if (!r) begin
      checkOutput("we3", obsWe, expWe);
      checkOutput("a3", obsA3, expA3);
      checkOutput("wd3", obsWd3, expWd3);
      checkOutput("stall", obsStall, modelForce);
      checkOutput("md_ready", obsReady, expReady);
      checkOutput("md_pending", obsPending, fifoQ.size() != 0);
    end
    @(posedge clk);
    if (r) begin
      fifoQ.delete();
      modelForce    = 1'b0;
      blockedCycles = 0;
    end else begin
      if (modelForce) begin
        modelForce    = 1'b0;
        blockedCycles = 0;
      end else if (fifoQ.size() > 0 && !doPop) begin
        blockedCycles++;
        if (blockedCycles == SL) begin
          modelForce    = 1'b1;
          blockedCycles = 0;
        end
      end else begin
        blockedCycles = 0;
      end
      if (doPop) void'(fifoQ.pop_front());
      if (doEnq) fifoQ.push_back('{rd: mrd, data: mdat});
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic          rR, rWen, rMv;
    logic [AW-1:0] rRd, rMrd;
    logic [DW-1:0] rRes, rMdat;
    checks = 0;
    errors = 0;
    modelForce = 1'b0;
    blockedCycles = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_ready", obsReady, 1);
    checkOutput("reset_we3", obsWe, 0);

    applyStimulus(0, 1, 7, 32'h55, 0, 0, 0);
    checkOutput("pipe_a3", obsA3, 7);
    checkOutput("pipe_wd3", obsWd3, 32'h55);

    applyStimulus(0, 0, 0, 0, 1, 3, 32'hA);
    checkOutput("enq_no_same_cycle_write", obsWe, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("drain_a3", obsA3, 3);
    checkOutput("drain_wd3", obsWd3, 32'hA);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("drain_pending", obsPending, 0);

    applyStimulus(0, 0, 0, 0, 1, 0, 32'h77);
    applyStimulus(0, 1, 0, 32'h99, 0, 0, 0);
    checkOutput("x0_pending", obsPending, 0);
    checkOutput("x0_we3", obsWe, 0);

    applyStimulus(0, 1, 5, 1, 1, 9, 32'h9A);
    applyStimulus(0, 1, 5, 2, 1, 11, 32'hBB);
    for (int i = 0; i < 8 && !obsStall; i++) applyStimulus(0, 1, 5, 3, 1, 12, 32'hCC);
    checkOutput("force_stall", obsStall, 1);
    checkOutput("force_a3", obsA3, 9);
    checkOutput("force_full_ready", obsReady, 0);
    applyStimulus(0, 1, 5, 3, 1, 12, 32'hCC);
    checkOutput("post_force_stall", obsStall, 0);
    checkOutput("post_force_a3", obsA3, 5);

    for (int i = 0; i < 8 && !modelForce; i++) applyStimulus(0, 1, 5, 4, 0, 0, 0);
    applyStimulus(1, 1, 5, 4, 0, 0, 0);
    checkOutput("rst_in_force_stall", obsStall, 1);
    checkOutput("rst_in_force_pending", obsPending, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_ready", obsReady, 1);
    checkOutput("post_rst_pending", obsPending, 0);
    checkOutput("post_rst_we3", obsWe, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_no_drain", obsWe, 0);

    for (int i = 0; i < 400; i++) begin
      rR    = ($urandom_range(0, 59) == 0);
      rWen  = ((i / 100) % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
      rRd   = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom_range(1, 31));
      rRes  = $urandom;
      rMv   = ($urandom_range(0, 2) != 0);
      rMrd  = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 31));
      rMdat = $urandom;
      applyStimulus(rR, rWen, rRd, rRes, rMv, rMrd, rMdat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- D_WIDTH, 32, register data width
- A_WIDTH, 5, register address width
- STARVE_LIMIT, 4, consecutive blocked cycles before a forced drain

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge
- rst, in, 1, synchronous, active-high reset
- reg_write_w_i, in, 1, pipeline W-stage write enable
- rd_w_i, in, A_WIDTH, pipeline W-stage destination register
- result_w_i, in, D_WIDTH, pipeline W-stage write data
- md_valid_i, in, 1, multi-cycle unit result valid
- md_ready_o, out, 1, block can accept the multi-cycle result
- md_rd_i, in, A_WIDTH, multi-cycle result destination register
- md_data_i, in, D_WIDTH, multi-cycle result data
- we3_o, out, 1, register-file write enable
- a3_o, out, A_WIDTH, register-file write address
- wd3_o, out, D_WIDTH, register-file write data
- stall_o, out, 1, pipeline freeze request; W stage holds and re-presents its write
- md_pending_o, out, 1, buffer non-empty

Function
REQ-003 The block SHALL hold multi-cycle results in a 2-entry FIFO.
- Enqueue when md_valid_i && md_ready_o && md_rd_i != 0.
- A result with md_rd_i == 0 that is handshaken SHALL be discarded and not stored.

REQ-004 md_ready_o SHALL be asserted exactly when the FIFO holds fewer than 2 entries. It is combinational from the occupancy count and independent of same-cycle dequeue.

REQ-005 pipe_req SHALL be defined as reg_write_w_i && rd_w_i != 0.

REQ-006 In state NORMAL:
- If pipe_req: we3_o=1, a3_o=rd_w_i, wd3_o=result_w_i.
- Else if FIFO non-empty: we3_o=1, a3_o/wd3_o = FIFO head, and the head SHALL be popped at the clock edge.
- Else: we3_o=0.

REQ-007 In state FORCE, the output and FIFO behaviour SHALL be:
- stall_o=1.
- we3_o=1 with a3_o/wd3_o from the FIFO head, regardless of pipe_req.
- The head SHALL be popped at the clock edge.
- The pipeline write SHALL NOT be performed in that cycle.

REQ-008 stall_o SHALL be 1 only in FORCE; it is a decode of the registered state.

REQ-009 we3_o, a3_o and wd3_o SHALL be combinational (zero latency from inputs/FIFO head). a3_o and wd3_o SHALL be 0 whenever we3_o=0.

REQ-010 starve_cnt (width clog2(STARVE_LIMIT)+1) SHALL update each edge as follows:
- In NORMAL, increment when the FIFO is non-empty and no pop occurs.
- Clear on any pop, when the FIFO is empty, and on entering FORCE.

REQ-011 The state SHALL transition as follows:
- NORMAL->FORCE when starve_cnt == STARVE_LIMIT-1 and the current cycle is again non-empty without a pop.
- FORCE->NORMAL unconditionally after one cycle; exactly one entry is drained per FORCE visit.

REQ-012 Simultaneous enqueue and pop SHALL leave the count unchanged. The enqueued entry goes behind the existing entries, and FIFO order is strictly preserved.

REQ-013 Enqueue into an empty FIFO SHALL NOT be written to the register file in the same cycle; the earliest write is the next cycle.

REQ-014 md_pending_o SHALL equal (count != 0), registered-state based.

REQ-015 WAW ordering between pipeline and buffered writes is guaranteed upstream by the scoreboard; this block SHALL NOT compare addresses.

Reset
REQ-016 On rst=1 at a clock edge, the block SHALL reset:
- state to NORMAL;
- FIFO count and pointers to 0;
- starve_cnt to 0.

REQ-017 In the cycle after reset, outputs SHALL be:
- stall_o=0, md_pending_o=0, md_ready_o=1;
- we3_o=0, a3_o=0, wd3_o=0 (absent pipe_req).

REQ-018 Reset asserted in FORCE or with a full FIFO SHALL discard all buffered results without a register-file write.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Pipeline only: reg_write_w_i=1, rd_w_i=7, result_w_i=0x55 -> same cycle we3_o=1, a3_o=7, wd3_o=0x55; stall_o=0.
- Idle drain: md (rd=3, data=0xA) enqueued at cycle N, no pipe_req -> at cycle N+1 we3_o=1, a3_o=3, wd3_o=0xA; md_pending_o=0 at N+2.
- Full: two md results enqueued while pipe_req is held high -> md_ready_o=0; a third md_valid_i is not accepted and is held by the source.
- Starvation with STARVE_LIMIT=4 and pipe_req held high on rd=5, FIFO holding rd=9 -> stall_o=1 on the 5th non-empty blocked cycle; in that cycle a3_o=9 and the rd=5 write is suppressed; the next cycle is NORMAL with rd=5 written.
- x0: md_rd_i=0 handshaken -> no FIFO entry, md_pending_o stays 0; pipe_req with rd_w_i=0 -> we3_o=0.
- Reset mid-FORCE with 2 entries -> next cycle count=0, stall_o=0, md_ready_o=1, no write of the buffered data.
